// File: rtl/icache_ctrl.sv
// Direct-mapped, read-only instruction cache controller: zero-latency hits,
// blocking single-block refill from instruction memory with a one-cycle MISS pulse.
module icache_ctrl #(
   parameter int ADDR_WIDTH      = 10,
   parameter int INDEX_BITS      = 3,
   parameter int WORDS_PER_BLOCK = 4
) (
   input  logic                                             CLOCK,
   input  logic                                             RESET,
   input  logic                                             READ,
   input  logic [ADDR_WIDTH-1:0]                            ADDRESS,
   output logic [31:0]                                      READDATA,
   output logic                                             BUSYWAIT,
   output logic                                             MISS,
   output logic                                             MEM_READ,
   output logic [ADDR_WIDTH-$clog2(WORDS_PER_BLOCK)-3:0]    MEM_ADDRESS,
   input  logic [32*WORDS_PER_BLOCK-1:0]                    MEM_READDATA,
   input  logic                                             MEM_BUSYWAIT
);

   localparam int WORD_SEL    = $clog2(WORDS_PER_BLOCK);
   localparam int OFFSET_BITS = WORD_SEL + 2;
   localparam int BLK_BITS    = ADDR_WIDTH - OFFSET_BITS;
   localparam int TAG_BITS    = BLK_BITS - INDEX_BITS;
   localparam int LINES       = 1 << INDEX_BITS;
   localparam int LINE_BITS   = 32 * WORDS_PER_BLOCK;

   typedef enum logic [1:0] {S_IDLE, S_MEM_READ, S_UPDATE} state_t;

   state_t                 state_q, state_d;
   logic                   miss_q, miss_d;
   logic                   mem_read_q, mem_read_d;
   logic [BLK_BITS-1:0]    mem_addr_q, mem_addr_d;
   logic [LINE_BITS-1:0]   fill_data_q, fill_data_d;
   logic [LINES-1:0]       valid_q, valid_d;
   logic                   line_we;

   logic [LINE_BITS-1:0]   data_q [LINES];
   logic [TAG_BITS-1:0]    tag_q  [LINES];

   logic [WORD_SEL-1:0]    req_offset;
   logic [INDEX_BITS-1:0]  req_index;
   logic [TAG_BITS-1:0]    req_tag;
   logic [INDEX_BITS-1:0]  fill_index;
   logic [TAG_BITS-1:0]    fill_tag;
   logic                   hit;
   logic                   unused_byte_sel;

   assign req_offset      = ADDRESS[OFFSET_BITS-1:2];
   assign req_index       = ADDRESS[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
   assign req_tag         = ADDRESS[ADDR_WIDTH-1:OFFSET_BITS+INDEX_BITS];
   assign unused_byte_sel = ^ADDRESS[1:0];

   // The latched block address already carries the refill's index and tag.
   assign fill_index = mem_addr_q[INDEX_BITS-1:0];
   assign fill_tag   = mem_addr_q[BLK_BITS-1:INDEX_BITS];

   assign hit      = READ & valid_q[req_index] & (tag_q[req_index] == req_tag);
   assign READDATA = data_q[req_index][32*req_offset +: 32];
   assign BUSYWAIT = (state_q == S_IDLE) ? (READ & ~hit) : 1'b1;

   assign MISS        = miss_q;
   assign MEM_READ    = mem_read_q;
   assign MEM_ADDRESS = mem_addr_q;

   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      state_d     = state_q;
      miss_d      = 1'b0;
      mem_read_d  = mem_read_q;
      mem_addr_d  = mem_addr_q;
      fill_data_d = fill_data_q;
      valid_d     = valid_q;
      line_we     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (READ && !hit) begin
               state_d    = S_MEM_READ;
               miss_d     = 1'b1;
               mem_read_d = 1'b1;
               mem_addr_d = ADDRESS[ADDR_WIDTH-1:OFFSET_BITS];
            end
         end
         S_MEM_READ: begin
            if (!MEM_BUSYWAIT) begin
               state_d     = S_UPDATE;
               mem_read_d  = 1'b0;
               fill_data_d = MEM_READDATA;
            end
         end
         S_UPDATE: begin
            state_d             = S_IDLE;
            valid_d[fill_index] = 1'b1;
            line_we             = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q    <= S_IDLE;
         miss_q     <= 1'b0;
         mem_read_q <= 1'b0;
         mem_addr_q <= '0;
         valid_q    <= '0;
      end else begin
         state_q    <= state_d;
         miss_q     <= miss_d;
         mem_read_q <= mem_read_d;
         mem_addr_q <= mem_addr_d;
         valid_q    <= valid_d;
      end
   end

   // NOTE: data/tag storage has no reset; the valid bits alone make stale contents harmless.
   always_ff @(posedge CLOCK) begin
      fill_data_q <= fill_data_d;
      if (line_we && !RESET) begin
         data_q[fill_index] <= fill_data_q;
         tag_q[fill_index]  <= fill_tag;
      end
   end

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: a line-level cache model predicts data, latency
// and miss addresses; a negedge monitor compares whatever the DUT presents.
module tb_icache_ctrl;

   logic         CLOCK = 1'b0;
   logic         RESET;
   logic         READ;
   logic [9:0]   ADDRESS;
   logic [31:0]  READDATA;
   logic         BUSYWAIT;
   logic         MISS;
   logic         MEM_READ;
   logic [5:0]   MEM_ADDRESS;
   logic [127:0] MEM_READDATA;
   logic         MEM_BUSYWAIT;

   always #5 CLOCK = ~CLOCK;

   icache_ctrl #(.ADDR_WIDTH(10), .INDEX_BITS(3), .WORDS_PER_BLOCK(4)) dut (
      .CLOCK        (CLOCK),
      .RESET        (RESET),
      .READ         (READ),
      .ADDRESS      (ADDRESS),
      .READDATA     (READDATA),
      .BUSYWAIT     (BUSYWAIT),
      .MISS         (MISS),
      .MEM_READ     (MEM_READ),
      .MEM_ADDRESS  (MEM_ADDRESS),
      .MEM_READDATA (MEM_READDATA),
      .MEM_BUSYWAIT (MEM_BUSYWAIT)
   );

   typedef struct {
      logic [31:0] data;
      int          issue;
      int          lat;      // -1: latency not checked
   } exp_t;

   int           vectors     = 0;
   int           miscompares = 0;
   int           cyc         = 0;
   int           mem_lat     = 4;
   int           mem_cnt     = 0;
   logic [127:0] mem_blocks [64];
   exp_t         exp_q [$];
   logic [5:0]   miss_exp_q [$];
   bit           model_valid [8];
   logic [2:0]   model_tag [8];
   int           model_misses = 0;
   int           seen_misses  = 0;
   logic         prev_miss    = 1'b0;
   exp_t         mon_e;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge CLOCK) cyc++;

   // Instruction memory: busy for mem_lat-1 cycles of a request, then data valid.
   always @(negedge CLOCK) begin
      if (MEM_READ) begin
         mem_cnt++;
         MEM_BUSYWAIT = (mem_cnt < mem_lat);
         MEM_READDATA = mem_blocks[MEM_ADDRESS];
      end else begin
         mem_cnt      = 0;
         MEM_BUSYWAIT = 1'b1;
         MEM_READDATA = {$urandom, $urandom, $urandom, $urandom};
      end
   end

   // Monitor
   always @(negedge CLOCK) begin
      if (!RESET) begin
         if (MISS) begin
            seen_misses++;
            check("miss_single_cycle", prev_miss, 1'b0);
            check("miss_with_mem_read", MEM_READ, 1'b1);
            if (miss_exp_q.size() == 0) check("miss_unexpected", 1'b1, 1'b0);
            else check("mem_address", MEM_ADDRESS, miss_exp_q.pop_front());
         end
         if (READ && !BUSYWAIT) begin
            if (exp_q.size() == 0) check("data_unexpected", 1'b1, 1'b0);
            else begin
               mon_e = exp_q.pop_front();
               check("readdata", READDATA, mon_e.data);
               if (mon_e.lat >= 0) check("latency", cyc - mon_e.issue, mon_e.lat);
               check("no_miss_on_hit", MISS, 1'b0);
               check("no_mem_read_on_hit", MEM_READ, 1'b0);
            end
         end
         if (!READ) begin
            check("idle_busywait", BUSYWAIT, 1'b0);
            check("idle_mem_read", MEM_READ, 1'b0);
         end
      end
      prev_miss = MISS;
   end

   // Reference model: record the outcome of a fetch to byte address a.
   task automatic model_fetch(input logic [9:0] a, input int lat_override);
      logic [5:0] blk;
      int         idx;
      bit         hit;
      exp_t       e;
      blk = a[9:4];
      idx = int'(a[6:4]);
      hit = model_valid[idx] && (model_tag[idx] == a[9:7]);
      if (!hit) begin
         miss_exp_q.push_back(blk);
         model_misses++;
         model_valid[idx] = 1'b1;
         model_tag[idx]   = a[9:7];
      end
      e.data  = mem_blocks[blk][32*int'(a[3:2]) +: 32];
      e.issue = cyc;
      e.lat   = (lat_override != 0) ? -1 : (hit ? 0 : mem_lat + 2);
      exp_q.push_back(e);
   endtask

   task automatic wait_done();
      bit done;
      done = 1'b0;
      for (int n = 0; n < 64 && !done; n++) begin
         @(negedge CLOCK);
         if (!BUSYWAIT) done = 1'b1;
      end
      if (!done) check("request_timeout", 1'b1, 1'b0);
   endtask

   task automatic do_req(input logic [9:0] a);
      @(posedge CLOCK); #1;
      READ    = 1'b1;
      ADDRESS = a;
      model_fetch(a, 0);
      wait_done();
   endtask

   task automatic idle(input int n);
      @(posedge CLOCK); #1;
      READ = 1'b0;
      for (int i = 0; i < n; i++) begin
         ADDRESS = 10'($urandom);
         @(negedge CLOCK);
      end
   endtask

   task automatic do_reset();
      @(posedge CLOCK); #1;
      RESET = 1'b1;
      READ  = 1'b0;
      @(posedge CLOCK); #1;
      RESET = 1'b0;
      for (int i = 0; i < 8; i++) model_valid[i] = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] a;
      for (int i = 0; i < 64; i++) mem_blocks[i] = {$urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < 8; i++) model_valid[i] = 1'b0;
      RESET        = 1'b1;
      READ         = 1'b0;
      ADDRESS      = '0;
      MEM_BUSYWAIT = 1'b1;
      MEM_READDATA = '0;
      repeat (2) @(posedge CLOCK);
      #1 RESET = 1'b0;

      @(negedge CLOCK);
      check("reset_miss", MISS, 1'b0);
      check("reset_mem_read", MEM_READ, 1'b0);
      check("reset_mem_address", MEM_ADDRESS, 6'h00);
      check("reset_busywait", BUSYWAIT, 1'b0);

      idle(10);

      // Cold miss then spatial hits within the same block
      mem_lat = 4;
      do_req(10'h000);
      do_req(10'h004);
      do_req(10'h008);
      do_req(10'h00C);

      // Conflict misses on index 1
      mem_lat = 2;
      do_req(10'h010);
      do_req(10'h090);
      do_req(10'h010);
      check("miss_count_conflict", seen_misses, 4);

      // Address change during refill is ignored; the new address misses afterwards
      do_reset();
      mem_lat = 3;
      @(posedge CLOCK); #1;
      READ    = 1'b1;
      ADDRESS = 10'h020;
      miss_exp_q.push_back(6'h02);
      model_misses++;
      model_valid[2] = 1'b1;
      model_tag[2]   = 3'd0;
      @(posedge CLOCK); #1;
      ADDRESS = 10'h300;
      model_fetch(10'h300, 1);
      @(negedge CLOCK);
      check("mem_address_held", MEM_ADDRESS, 6'h02);
      wait_done();
      do_req(10'h024);

      // Reset in the second MEM_READ cycle abandons the refill
      do_reset();
      mem_lat = 4;
      @(posedge CLOCK); #1;
      READ    = 1'b1;
      ADDRESS = 10'h140;
      miss_exp_q.push_back(6'h14);
      model_misses++;
      @(posedge CLOCK); #1;
      @(posedge CLOCK); #1;
      RESET = 1'b1;
      READ  = 1'b0;
      @(posedge CLOCK); #1;
      RESET = 1'b0;
      for (int i = 0; i < 8; i++) model_valid[i] = 1'b0;
      @(negedge CLOCK);
      check("reset_refill_mem_read", MEM_READ, 1'b0);
      check("reset_refill_miss", MISS, 1'b0);
      idle(6);
      do_req(10'h140);

      // Randomized traffic over a few tags to mix hits and conflicts
      for (int i = 0; i < 250; i++) begin
         mem_lat = $urandom_range(1, 5);
         a = {3'($urandom_range(0, 2)), 3'($urandom), 2'($urandom), 2'($urandom)};
         do_req(a);
         if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      end

      idle(4);
      check("miss_count_total", seen_misses, model_misses);
      check("data_queue_drained", exp_q.size(), 0);
      check("miss_queue_drained", miss_exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
